// File: rtl/bucket_pkg.sv
// Shared types and the code-to-word decode for the bucket stimulus transmitter.
package bucket_pkg;
  localparam int CODE_W   = 4;
  localparam int WORD_W   = 10;
  localparam int MAX_CODE = 9;

  localparam logic [WORD_W-1:0] TRIG_WORD = 10'b00_0000_1011;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    TRIG
  } tx_state_e;

  // Lowest value of each encoder bucket; illegal codes decode to 0.
  function automatic logic [WORD_W-1:0] bucket_decode(input logic [CODE_W-1:0] code);
    logic [WORD_W-1:0] w;
    w = '0;
    if (code == CODE_W'(1))
      w = WORD_W'(1);
    else if (code >= CODE_W'(2) && code <= CODE_W'(MAX_CODE))
      w = WORD_W'(1) << code;
    return w;
  endfunction
endpackage

// File: rtl/code_fifo.sv
// Synchronous code FIFO; pointers carry one extra wrap bit to tell full from empty.
module code_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         c,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge c) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: it is only read behind a valid pointer.
  always_ff @(posedge c) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/bucket_code_tx.sv
// Expands queued bucket codes into checker stimulus words, each held HOLD clocks.
// BUCKET_TX_TRIG_EN compiles in the one-shot capture-trigger word path.
module bucket_code_tx
  import bucket_pkg::*;
#(
  parameter int HOLD  = 1,
  parameter int DEPTH = 4
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              trig_req,
  output logic [WORD_W-1:0] o,
  output logic              o_valid,
  output logic              busy,
  output logic              err
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  tx_state_e         state, state_nxt;
  logic [WORD_W-1:0] word_q, word_nxt;
  logic [CW-1:0]     cnt_q, cnt_nxt;
  logic [CODE_W-1:0] head;
  logic              full, empty, push, pop, legal, last, trig_go;

  assign legal    = (in_code <= CODE_W'(MAX_CODE));
  assign in_ready = rst_n & ~full;
  assign push     = in_valid & in_ready & legal;
  assign last     = (cnt_q == CW'(HOLD-1));
  assign busy     = (state != IDLE) | ~empty;

  code_fifo #(.DEPTH(DEPTH), .W(CODE_W)) u_fifo (
    .c     (c),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_code),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

`ifdef BUCKET_TX_TRIG_EN
  logic pend_q;
  logic enter_trig;

  assign trig_go    = pend_q;
  assign enter_trig = (state_nxt == TRIG) && (state != TRIG);

  // A request landing on the entry cycle re-arms the flag for a later trigger.
  always_ff @(posedge c) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= (pend_q & ~enter_trig) | trig_req;
  end
`else
  logic unused_trig;
  assign unused_trig = trig_req;
  assign trig_go     = 1'b0;
`endif

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state  <= IDLE;
      word_q <= '0;
      cnt_q  <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      word_q <= word_nxt;
      cnt_q  <= cnt_nxt;
      err    <= in_valid & ~legal;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word_q;
    cnt_nxt   = cnt_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (trig_go) begin
          state_nxt = TRIG;
        end else if (!empty) begin
          pop       = 1'b1;
          word_nxt  = bucket_decode(head);
          cnt_nxt   = '0;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (!last) begin
          cnt_nxt = cnt_q + CW'(1);
        end else if (trig_go) begin
          state_nxt = TRIG;
        end else if (!empty) begin
          // Reload on the boundary so consecutive words abut with no gap.
          pop      = 1'b1;
          word_nxt = bucket_decode(head);
          cnt_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      TRIG:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o       = '0;
    o_valid = 1'b0;
    case (state)
      EMIT: begin
        o       = word_q;
        o_valid = 1'b1;
      end
`ifdef BUCKET_TX_TRIG_EN
      TRIG: begin
        o       = TRIG_WORD;
        o_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule
